alu_mdu_ctrl: RTL
=================

Name: alu_mdu_ctrl

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes aluop/func into the ALU control bus and adds an iterative multiply/divide unit (MDU) with HI/LO registers. It sits in the EX stage. Combinational ALU decode runs alongside a sequential MDU that raises a stall to the pipeline when a HI/LO consumer meets an in-flight operation.

Parameters:
WIDTH, 32, datapath width; operand, HI and LO width; iteration count.
CTRL_W, 4, width of alu_control; must equal the shared-package ALU control length.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
valid  in  1  EX stage holds a live instruction this cycle
aluop  in  2  main-decoder ALU class (ADD, SUB, ORI, R_TYPE)
func  in  6  R-type function field
rs_val  in  WIDTH  operand A; also MTHI/MTLO source
rt_val  in  WIDTH  operand B
alu_control  out  CTRL_W  ALU operation select (combinational)
hilo_rdata  out  WIDTH  HI for MFHI, LO for MFLO, else 0
hilo_rd  out  1  current instruction is MFHI/MFLO and is not stalled
stall  out  1  freeze IF/ID/EX this cycle
mdu_busy  out  1  MDU FSM not in IDLE

Behaviour:
- alu_control is combinational, zero latency.
  - aluop ADD→ADD, SUB→SUBU, ORI→ORI.
  - R_TYPE decodes func: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA.
  - Any other func, including MDU and HI/LO funcs, gives CTRL_NOP (all zeros).
- MDU ops: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO. They are recognised only when valid=1 and aluop=R_TYPE.
- FSM states:
  - IDLE: accepts a new op.
  - RUN: WIDTH iterations; a cycle counter counts 0..WIDTH-1.
  - FIX: sign correction and HI/LO write.
- Start: in IDLE, a MULT/MULTU/DIV/DIVU issue latches operand magnitudes and sign flags and goes to RUN. stall=0 in the accept cycle; the pipeline continues.
- RUN:
  - Multiply is radix-2 shift-add.
  - Divide is restoring, one quotient bit per cycle.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX:
  - Negate results as required. Signed multiply: product negated if signs differ. Signed divide: quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI/LO at the end of the cycle, then go to IDLE.
- Latency: accept at cycle t; HI/LO hold the new value from cycle t+WIDTH+2.
- stall=1 when valid and the current instruction is any MDU op while the FSM is not IDLE. This includes a second MULT/DIV and MTHI/MTLO.
  - While stalled: no HI/LO read, no write, no accept.
  - stall drops in the first IDLE cycle. The instruction then executes normally in that cycle.
- MFHI/MFLO in IDLE: hilo_rdata shows the register value the same cycle and hilo_rd=1.
- MTHI/MTLO in IDLE: HI/LO takes rs_val at the end of the cycle.
- Divide by zero: LO=all ones, HI=dividend (rs_val); still takes the full WIDTH+2 cycles.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- valid=0: nothing is accepted and stall=0, but an in-flight op continues.
- Reset (any time, including mid-RUN):
  - FSM=IDLE, counter=0, HI=LO=0, internal accumulators cleared.
  - Outputs: stall=0, mdu_busy=0, hilo_rd=0, hilo_rdata=0.
  - The aborted op leaves no trace.
- Widths:
  - Product is 2*WIDTH bits: HI=upper WIDTH bits, LO=lower WIDTH bits.
  - Divide: LO=quotient, HI=remainder.
  - All internal arithmetic is unsigned on magnitudes; the counter is clog2(WIDTH) bits.

Decomposition:
- Shared head package:
  - Existing ALU_OP_* and ALU_CONLROL_*/length constants.
  - New FUNC_* codes: AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - New ALU_CONLROL_* values plus CTRL_NOP.
  - MDU state encodings.
- ALU decode stays in this module using MuxKey.
- One natural sub-module: mdu_iter, the iterative mul/div datapath (start, op, operands → done, hi, lo). This module keeps the FSM, stall logic and HI/LO registers.

Test Plan:
1. Decode sweep: aluop=R_TYPE, func=ADDU/SUBU/SLT/SRA; plus aluop=ORI → matching ALU_CONLROL_* the same cycle. Func=MULT → CTRL_NOP.
2. MULTU 0xFFFFFFFF×0x2 accepted at t → HI=0x1, LO=0xFFFFFFFE readable by MFLO at t+34. mdu_busy=1 for exactly 33 cycles.
3. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. MFHI issued at t+1 stalls until t+34, then returns 0xFFFFFFFF with hilo_rd=1.
4. DIVU 5/0 → LO=0xFFFFFFFF, HI=0x5. DIV 0x80000000/-1 → LO=0x80000000, HI=0.
5. MTHI 0x1234 in IDLE → the next-cycle MFHI returns 0x1234. A MULT issued immediately after a running DIV is stalled, then accepted on the first IDLE cycle.
6. Assert rst at RUN iteration 10 of a MULT → next cycle: IDLE, stall=0, HI=LO=0, mdu_busy=0. A following MFLO returns 0.

Source files
------------

// File: rtl/alu_mdu_ctrl_pkg.sv
// rtl/alu_mdu_ctrl_pkg.sv - shared ALU/MDU decode constants, codes and MDU state type
// Purpose: aluop classes, R-type func codes, ALU control encodings and the MDU
//          state encoding shared by the EX-stage control and its testbench.
// Ports:   none (package).
package alu_mdu_ctrl_pkg;

  // Main-decoder ALU classes
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_ORI    = 2'b10;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'b11;

  // ALU control bus
  localparam int ALU_CONLROL_LEN = 4;
  localparam logic [ALU_CONLROL_LEN-1:0] CTRL_NOP          = 4'd0;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_ADD   = 4'd1;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SUBU  = 4'd2;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_ORI   = 4'd3;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_ADDU  = 4'd4;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_AND   = 4'd5;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_OR    = 4'd6;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_XOR   = 4'd7;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_NOR   = 4'd8;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SLT   = 4'd9;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SLTU  = 4'd10;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SLL   = 4'd11;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SRL   = 4'd12;
  localparam logic [ALU_CONLROL_LEN-1:0] ALU_CONLROL_SRA   = 4'd13;

  // R-type function field codes
  localparam logic [5:0] FUNC_SLL   = 6'h00;
  localparam logic [5:0] FUNC_SRL   = 6'h02;
  localparam logic [5:0] FUNC_SRA   = 6'h03;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1a;
  localparam logic [5:0] FUNC_DIVU  = 6'h1b;
  localparam logic [5:0] FUNC_ADDU  = 6'h21;
  localparam logic [5:0] FUNC_SUBU  = 6'h23;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_XOR   = 6'h26;
  localparam logic [5:0] FUNC_NOR   = 6'h27;
  localparam logic [5:0] FUNC_SLT   = 6'h2a;
  localparam logic [5:0] FUNC_SLTU  = 6'h2b;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // Any func that touches the MDU or HI/LO (and so can be stalled)
  function automatic logic is_mdu_func(input logic [5:0] f);
    return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU,
                     FUNC_MFHI, FUNC_MFLO, FUNC_MTHI, FUNC_MTLO};
  endfunction

  // Funcs that launch an iterative operation
  function automatic logic is_start_func(input logic [5:0] f);
    return f inside {FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
  endfunction

endpackage

// File: rtl/alu_mdu_ctrl_iter.sv
// rtl/alu_mdu_ctrl_iter.sv - iterative unsigned shift-add multiply / restoring divide datapath
// Purpose: WIDTH-step magnitude multiply or divide, one bit per run cycle.
// Ports:   clk, rst      clock, synchronous active-high reset
//          start         load magnitudes and op (one cycle)
//          run           advance one iteration
//          is_div        op select at start: 1=divide, 0=multiply
//          a_mag, b_mag  multiplier/dividend and multiplicand/divisor magnitudes
//          done          last iteration happens this cycle
//          hi, lo        product {hi,lo}, or remainder (hi) and quotient (lo)
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum, shifted, diff;

  assign done = run && (cnt_q == CNT_LAST);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    div_d   = div_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (start) begin
      cnt_d = '0;
      hi_d  = '0;
      lo_d  = a_mag;
      b_d   = b_mag;
      div_d = is_div;
    end else if (run) begin
      cnt_d = done ? '0 : cnt_q + 1'b1;
      if (div_q) begin
        // Restoring step: bring in the next dividend bit, subtract if it fits.
        // diff[WIDTH] is the borrow, i.e. the partial remainder was too small.
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        // Shift-add: the multiplier drains out of lo as the product shifts in.
        sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// rtl/alu_mdu_ctrl.sv - EX-stage ALU control decode with iterative MDU, HI/LO and stall
// Purpose: combinational aluop/func -> alu_control decode; MDU FSM (IDLE/RUN/FIX)
//          with sign handling, HI/LO registers and HI/LO hazard stall.
// Ports:   clk, rst        clock, synchronous active-high reset
//          valid           live instruction in EX
//          aluop, func     ALU class and R-type function field
//          rs_val, rt_val  operands (rs_val also MTHI/MTLO source)
//          alu_control     ALU operation select
//          hilo_rdata      HI/LO read data for MFHI/MFLO, else 0
//          hilo_rd         MFHI/MFLO executing this cycle
//          stall           freeze IF/ID/EX
//          mdu_busy        MDU not idle
module alu_mdu_ctrl
  import alu_mdu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = ALU_CONLROL_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [1:0]        aluop,
  input  logic [5:0]        func,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  output logic [CTRL_W-1:0] alu_control,
  output logic [WIDTH-1:0]  hilo_rdata,
  output logic              hilo_rd,
  output logic              stall,
  output logic              mdu_busy
);

  logic [ALU_CONLROL_LEN-1:0] ctrl;

  always_comb begin
    ctrl = CTRL_NOP;
    case (aluop)
      ALU_OP_ADD: ctrl = ALU_CONLROL_ADD;
      ALU_OP_SUB: ctrl = ALU_CONLROL_SUBU;
      ALU_OP_ORI: ctrl = ALU_CONLROL_ORI;
      ALU_OP_R_TYPE: begin
        case (func)
          FUNC_ADDU: ctrl = ALU_CONLROL_ADDU;
          FUNC_SUBU: ctrl = ALU_CONLROL_SUBU;
          FUNC_AND:  ctrl = ALU_CONLROL_AND;
          FUNC_OR:   ctrl = ALU_CONLROL_OR;
          FUNC_XOR:  ctrl = ALU_CONLROL_XOR;
          FUNC_NOR:  ctrl = ALU_CONLROL_NOR;
          FUNC_SLT:  ctrl = ALU_CONLROL_SLT;
          FUNC_SLTU: ctrl = ALU_CONLROL_SLTU;
          FUNC_SLL:  ctrl = ALU_CONLROL_SLL;
          FUNC_SRL:  ctrl = ALU_CONLROL_SRL;
          FUNC_SRA:  ctrl = ALU_CONLROL_SRA;
          default:   ctrl = CTRL_NOP;
        endcase
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign alu_control = CTRL_W'(ctrl);

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, div_q, div_d, dz_q, dz_d;

  logic             is_r, idle, accept, op_signed, op_div, iter_done;
  logic [WIDTH-1:0] a_mag, b_mag, iter_hi, iter_lo, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  assign is_r      = valid && (aluop == ALU_OP_R_TYPE);
  assign idle      = (state_q == MDU_IDLE);
  assign accept    = is_r && is_start_func(func) && idle;
  assign op_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
  assign op_div    = (func == FUNC_DIV) || (func == FUNC_DIVU);
  assign a_mag     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign b_mag     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .run    (state_q == MDU_RUN),
    .is_div (op_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .done   (iter_done),
    .hi     (iter_hi),
    .lo     (iter_lo)
  );

  // Sign correction: remainder follows the dividend, quotient/product the sign XOR.
  // most-negative / -1 falls out naturally: quotient magnitude 2^(W-1) negates to itself.
  assign prod_raw = {iter_hi, iter_lo};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_raw : prod_raw;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -iter_lo : iter_lo;
  assign rem_fix  = neg_a_q ? -iter_hi : iter_hi;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div_d   = div_q;
    dz_d    = dz_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          state_d = MDU_RUN;
          neg_a_d = op_signed && rs_val[WIDTH-1];
          neg_b_d = op_signed && rt_val[WIDTH-1];
          div_d   = op_div;
          dz_d    = (rt_val == '0);
        end else if (is_r && (func == FUNC_MTHI)) begin
          hi_d = rs_val;
        end else if (is_r && (func == FUNC_MTLO)) begin
          lo_d = rs_val;
        end
      end
      MDU_RUN: begin
        if (iter_done) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        if (div_q) begin
          // Divide by zero: raw remainder is |dividend|, so rem_fix restores rs_val.
          lo_d = dz_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end

  // Outputs are forced quiet during the reset cycle itself, even mid-operation.
  assign mdu_busy   = !rst && !idle;
  assign stall      = !rst && is_r && is_mdu_func(func) && !idle;
  assign hilo_rd    = !rst && is_r && idle && ((func == FUNC_MFHI) || (func == FUNC_MFLO));
  assign hilo_rdata = !hilo_rd ? '0 : (func == FUNC_MFHI) ? hi_q : lo_q;

endmodule
